uart_reg_responder: RTL and testbench

Command responder between `uart_rx` and `uart_tx` on the 60 MHz domain. It is the device end of the host's register-access protocol: it consumes received bytes, decodes write and read commands against an internal 8-bit register file, and sends exactly one reply byte per command. Register 0 is exported for LEDs/debug. It replaces the plain echo loopback in the top level.

---
 rtl/uart_reg_responder.sv | 158 +++++++++++++++
 tb/tb_uart_reg_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
`default_nettype none
// ============================================================================
// uart_reg_responder : W/R register-access command responder, one reply/cmd
// Revision 1.0
// ============================================================================
module uart_reg_responder #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 600000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rxdata,
    input  logic       rxvalid,
    output logic       rxack,
    output logic [7:0] txdata,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [7:0] reg0,
    output logic       busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);
    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] REPLY_OK  = 8'h4B;
    localparam logic [7:0] REPLY_ERR = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_EXEC,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t           state, state_next;
    logic             ack_q;
    logic [7:0]       opcode;
    logic [7:0]       addr;
    logic [7:0]       wdata;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       regs [0:DEPTH-1];

    logic             accept;
    logic             in_arg;
    logic             timed_out;
    logic             addr_ok;
    logic             do_write;
    logic [7:0]       reply;

    always_comb begin
        // gated by rst so rxack stays low while reset is held
        accept    = (state inside {S_IDLE, S_GET_ADDR, S_GET_DATA}) && rxvalid && !ack_q && rst;
        in_arg    = (state == S_GET_ADDR) || (state == S_GET_DATA);
        timed_out = in_arg && !accept && (cnt == CNT_LAST);
        addr_ok   = ((addr >> ADDR_W) == 8'd0);
        do_write  = (opcode == OP_WRITE) && addr_ok;
        if (opcode == OP_WRITE)
            reply = addr_ok ? REPLY_OK : REPLY_ERR;
        else if (opcode == OP_READ)
            reply = addr_ok ? regs[addr[ADDR_W-1:0]] : REPLY_ERR;
        else
            reply = REPLY_ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        rxack      = accept;
        tx_start   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_next = (rxdata == OP_WRITE || rxdata == OP_READ) ? S_GET_ADDR : S_EXEC;
            end
            S_GET_ADDR: begin
                if (accept)
                    state_next = (opcode == OP_WRITE) ? S_GET_DATA : S_EXEC;
                else if (timed_out)
                    state_next = S_IDLE;
            end
            S_GET_DATA: begin
                if (accept)
                    state_next = S_EXEC;
                else if (timed_out)
                    state_next = S_IDLE;
            end
            S_EXEC: state_next = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy)
                    state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q  <= 1'b0;
            opcode <= 8'h00;
            addr   <= 8'h00;
            wdata  <= 8'h00;
            cnt    <= '0;
            txdata <= 8'h00;
        end else begin
            ack_q <= accept;
            if (accept) begin
                case (state)
                    S_IDLE:     opcode <= rxdata;
                    S_GET_ADDR: addr   <= rxdata;
                    S_GET_DATA: wdata  <= rxdata;
                    default: ;
                endcase
            end
            // counter only runs while waiting for argument bytes
            if (accept || !in_arg)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == S_EXEC)
                txdata <= reply;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= 8'h00;
        end else if (state == S_EXEC && do_write) begin
            regs[addr[ADDR_W-1:0]] <= wdata;
        end
    end

    assign reg0 = regs[0];
    assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_responder.sv
`default_nettype none
// ============================================================================
// tb_uart_reg_responder : directed bench for the UART register responder
// Revision 1.0
// ============================================================================
module tb_uart_reg_responder;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       rxack;
    logic [7:0] txdata;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] reg0;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_reg_responder #(.ADDR_W(4), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxdata   (rxdata),
        .rxvalid  (rxvalid),
        .rxack    (rxack),
        .txdata   (txdata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .reg0     (reg0),
        .busy     (busy)
    );

    // uart_rx model: offer a byte, keep it one cycle past the ack, then drop it.
    // Returns at the falling edge two cycles after the ack cycle.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 0;
        @(negedge clk);
        rxdata  = b;
        rxvalid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (rxack) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL ack_timeout byte=%02h: rxack got 0, required 1", b);
            rxvalid = 1'b0;
            return;
        end
        @(negedge clk);
        #1;
        tests++;
        if (rxack !== 1'b0) begin
            fails++;
            $display("FAIL ack_blanking byte=%02h: rxack got %b, required 0", b, rxack);
        end
        @(negedge clk);
        rxvalid = 1'b0;
    endtask

    // uart_tx model: catch tx_start, then run a short busy pulse
    task automatic get_reply(output logic [7:0] b);
        bit got;
        got = 0;
        b   = 8'h00;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (tx_start) begin
                got = 1;
                b   = txdata;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL reply_timeout: tx_start got 0, required 1");
            return;
        end
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_hold: busy got %b, required 1", busy);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_fall: busy got %b, required 0", busy);
        end
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        rxdata  = 8'h00;
        rxvalid = 1'b0;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        rxdata  = 8'h57;
        rxvalid = 1'b1;
        #1;
        tests++;
        if ({busy, rxack, tx_start} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: busy/rxack/tx_start got %b, required 000", {busy, rxack, tx_start});
        end
        tests++;
        if ({txdata, reg0} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: txdata/reg0 got %04h, required 0000", {txdata, reg0});
        end
        rxvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        logic [7:0] r;
        send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
        get_reply(r);
        tests++;
        if (r !== 8'h4B) begin
            fails++;
            $display("FAIL wr_reply: got %02h, required 4b", r);
        end
        send_byte(8'h52); send_byte(8'h03);
        get_reply(r);
        tests++;
        if (r !== 8'hA5) begin
            fails++;
            $display("FAIL rd_reply: got %02h, required a5", r);
        end
    endtask

    task automatic test_reg0_export;
        logic [7:0] r;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h3C);
        #1;
        tests++;
        if (reg0 !== 8'h3C) begin
            fails++;
            $display("FAIL reg0_n2: got %02h, required 3c", reg0);
        end
        tests++;
        if (tx_start !== 1'b1) begin
            fails++;
            $display("FAIL tx_start_n2: got %b, required 1", tx_start);
        end
        get_reply(r);
        tests++;
        if (r !== 8'h4B) begin
            fails++;
            $display("FAIL reg0_reply: got %02h, required 4b", r);
        end
    endtask

    task automatic test_unknown_opcode;
        logic [7:0] r;
        int extra;
        send_byte(8'h41);
        get_reply(r);
        tests++;
        if (r !== 8'h3F) begin
            fails++;
            $display("FAIL unk_reply: got %02h, required 3f", r);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (tx_start) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL unk_single: extra tx_start got %0d, required 0", extra);
        end
        tests++;
        if (reg0 !== 8'h3C) begin
            fails++;
            $display("FAIL unk_reg0: got %02h, required 3c", reg0);
        end
    endtask

    task automatic test_out_of_range;
        logic [7:0] r;
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hFF);
        get_reply(r);
        tests++;
        if (r !== 8'h3F) begin
            fails++;
            $display("FAIL oor_wr_reply: got %02h, required 3f", r);
        end
        tests++;
        if (reg0 !== 8'h3C) begin
            fails++;
            $display("FAIL oor_alias: reg0 got %02h, required 3c", reg0);
        end
        send_byte(8'h52); send_byte(8'h10);
        get_reply(r);
        tests++;
        if (r !== 8'h3F) begin
            fails++;
            $display("FAIL oor_rd_reply: got %02h, required 3f", r);
        end
        send_byte(8'h52); send_byte(8'h03);
        get_reply(r);
        tests++;
        if (r !== 8'hA5) begin
            fails++;
            $display("FAIL oor_reg3: got %02h, required a5", r);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] r;
        int starts;
        starts = 0;
        send_byte(8'h57); send_byte(8'h05);
        repeat (TMO - 3) begin
            @(negedge clk);
            #1;
            if (tx_start) starts++;
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL tmo_early: busy at N+T-1 got %b, required 1", busy);
        end
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_idle: busy at N+T got %b, required 0", busy);
        end
        repeat (5) begin
            @(negedge clk);
            #1;
            if (tx_start) starts++;
        end
        tests++;
        if (starts !== 0) begin
            fails++;
            $display("FAIL tmo_silent: tx_start count got %0d, required 0", starts);
        end
        send_byte(8'h52); send_byte(8'h05);
        get_reply(r);
        tests++;
        if (r !== 8'h00) begin
            fails++;
            $display("FAIL tmo_no_write: got %02h, required 00", r);
        end
    endtask

    task automatic test_timeout_boundary;
        logic [7:0] r;
        send_byte(8'h57); send_byte(8'h06);
        repeat (TMO - 3) @(negedge clk);
        rxdata  = 8'h77;
        rxvalid = 1'b1;
        #1;
        tests++;
        if (rxack !== 1'b1) begin
            fails++;
            $display("FAIL tmo_last_cycle: rxack got %b, required 1", rxack);
        end
        @(negedge clk);
        @(negedge clk);
        rxvalid = 1'b0;
        get_reply(r);
        tests++;
        if (r !== 8'h4B) begin
            fails++;
            $display("FAIL tmo_edge_reply: got %02h, required 4b", r);
        end
        send_byte(8'h52); send_byte(8'h06);
        get_reply(r);
        tests++;
        if (r !== 8'h77) begin
            fails++;
            $display("FAIL tmo_edge_read: got %02h, required 77", r);
        end
    endtask

    task automatic test_busy_stall;
        int early_starts;
        int stray_acks;
        early_starts = 0;
        stray_acks   = 0;
        tx_busy = 1'b1;
        send_byte(8'h52); send_byte(8'h03);
        rxdata  = 8'h41;
        rxvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (tx_start) early_starts++;
            if (rxack) stray_acks++;
            @(negedge clk);
        end
        tests++;
        if (early_starts !== 0) begin
            fails++;
            $display("FAIL stall_start: tx_start count got %0d, required 0", early_starts);
        end
        tests++;
        if (stray_acks !== 0) begin
            fails++;
            $display("FAIL stall_rxack: rxack count got %0d, required 0", stray_acks);
        end
        rxvalid = 1'b0;
        tx_busy = 1'b0;
        #1;
        tests++;
        if ({tx_start, txdata} !== {1'b1, 8'hA5}) begin
            fails++;
            $display("FAIL stall_release: tx_start/txdata got %b/%02h, required 1/a5", tx_start, txdata);
        end
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL stall_done: busy got %b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_command;
        logic [7:0] r;
        send_byte(8'h57); send_byte(8'h08);
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: busy got %b, required 1", busy);
        end
        rxdata  = 8'hAA;
        rxvalid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({busy, rxack, tx_start} !== 3'b000) begin
            fails++;
            $display("FAIL rstmid_ctrl: busy/rxack/tx_start got %b, required 000", {busy, rxack, tx_start});
        end
        tests++;
        if ({txdata, reg0} !== 16'h0000) begin
            fails++;
            $display("FAIL rstmid_data: txdata/reg0 got %04h, required 0000", {txdata, reg0});
        end
        rxvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'hAA);
        get_reply(r);
        tests++;
        if (r !== 8'h3F) begin
            fails++;
            $display("FAIL rstmid_fresh: got %02h, required 3f", r);
        end
        send_byte(8'h52); send_byte(8'h08);
        get_reply(r);
        tests++;
        if (r !== 8'h00) begin
            fails++;
            $display("FAIL rstmid_nowrite: got %02h, required 00", r);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg0_export();
        test_unknown_opcode();
        test_out_of_range();
        test_timeout();
        test_timeout_boundary();
        test_busy_stall();
        test_reset_mid_command();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
